mod_reg16_16to1: RTL and testbench

- Downstream neighbour of the 1-to-16 byte deserializer. Takes a full 16-byte AES state (cipher output) in one cycle and streams it out one byte per accepted transfer.
- Byte order is index 0 first, matching the order in which the deserializer fills its register.
- Holds a two-slot buffer (active + pending) so a new block can be loaded while the current one drains, with zero-bubble back-to-back output.

---
 rtl/mod_reg16_16to1.sv | 122 ++++++++++++
 tb/tb_mod_reg16_16to1.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reg16_16to1.sv
// rtl/mod_reg16_16to1.sv - 16-to-1 byte serializer with active + pending block slots
//
// Purpose:
//   Accepts a whole N-byte block in one cycle and streams it out one byte per
//   accepted transfer, byte 0 first. A second block can be parked in the
//   pending slot while the active one drains. The pending block is promoted
//   with no idle cycle between the last byte of one block and byte 0 of the
//   next.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-high; discards any active or pending block
//   in_valid - block on i is offered
//   in_ready - a block slot is free (registered state only)
//   i        - N-byte input block, i[0] is sent first
//   o        - current byte (zero while o_valid is low)
//   o_valid  - o holds a valid byte
//   o_ready  - sink accepts o this cycle
//   o_last   - o carries byte N-1 of a block
//   busy     - a byte is being presented or a block is pending

module mod_reg16_16to1 #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0][W-1:0] i,
  output logic [W-1:0]        o,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                o_last,
  output logic                busy
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N-1:0][W-1:0]  cur_q, cur_d;
  logic [N-1:0][W-1:0]  pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;

  logic accept;
  logic xfer;
  logic at_last;

  // in_ready depends on the pending flag only, so it never combinationally
  // follows o_ready or in_valid.
  assign accept  = in_valid && !pend_full_q;
  assign xfer    = (state_q == SEND) && o_ready;
  assign at_last = (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_d   = i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && at_last) begin
          cnt_d = '0;
          // A full pending slot blocks accept, so at most one of these
          // branches can load cur.
          if (pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            cur_d = i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (accept) begin
            pend_d      = i;
            pend_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign o_valid  = (state_q == SEND);
  assign o        = o_valid ? cur_q[cnt_q] : '0;
  assign o_last   = o_valid && at_last;
  assign in_ready = !pend_full_q;
  assign busy     = o_valid || pend_full_q;

endmodule

// File: tb/tb_mod_reg16_16to1.sv
// tb/tb_mod_reg16_16to1.sv - self-checking bench for mod_reg16_16to1
module tb_mod_reg16_16to1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [15:0][7:0]    i = '0;
  logic [7:0]          o;
  logic                o_valid;
  logic                o_ready = 1'b1;
  logic                o_last;
  logic                busy;

  mod_reg16_16to1 #(.N(16), .W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .i        (i),
    .o        (o),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_last   (o_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         xfers  = 0;
  int         done   = 0;
  int         mode   = 0;   // 0: o_ready=1, 1: toggle, 2: random
  logic [8:0] q[$];         // {last, byte}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0][7:0] mk(input logic [7:0] base);
    logic [15:0][7:0] b;
    for (int k = 0; k < 16; k++) b[k] = base + 8'(k);
    return b;
  endfunction

  task automatic push_blk(input logic [7:0] base);
    for (int k = 0; k < 16; k++) q.push_back({(k == 15), base + 8'(k)});
  endtask

  // Sink-side ready generator, changes away from the active edge.
  always begin
    @(negedge clk);
    case (mode)
      1:       o_ready = ~o_ready;
      2:       o_ready = 1'($urandom_range(0, 1));
      default: o_ready = 1'b1;
    endcase
  end

  // Monitor / scoreboard: at negedge+2 the sampled o_valid && o_ready is the
  // transfer that the next rising edge performs.
  logic       prev_stall = 1'b0;
  logic       prev_last  = 1'b0;
  logic [7:0] prev_o     = '0;
  always begin
    logic [8:0] e;
    @(negedge clk);
    #2;
    if (reset) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 32'(o_valid), 32'd1);
        chk("stall_o_hold", 32'(o), 32'(prev_o));
      end
      if (prev_last) chk("ready_after_last", 32'(in_ready), 32'd1);
      if (mode == 0 && q.size() > 0) chk("no_bubble", 32'(o_valid), 32'd1);
      if (!o_valid) chk("idle_outputs_zero", 32'({o, o_last}), 32'd0);
      if (o_valid && o_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_byte", 32'(o), 32'h1ff);
        end else begin
          e = q.pop_front();
          chk("byte", 32'(o), 32'(e[7:0]));
          chk("last", 32'(o_last), 32'(e[8]));
        end
        xfers++;
        if (o_last) done++;
      end
      prev_stall = o_valid && !o_ready;
      prev_last  = o_valid && o_ready && o_last;
      prev_o     = o;
    end
  end

  task automatic offer(input logic [7:0] base);
    int n;
    in_valid = 1'b1;
    i        = mk(base);
    n        = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_blk(base);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while ((q.size() != 0 || busy) && n < 2000);
    chk("drain", 32'(q.size() == 0 && !busy), 32'd1);
  endtask

  typedef struct {
    logic [7:0] base;
    int         rmode;
    int         nblk;
    int         exp_count;
  } vec_t;

  vec_t tab[4];

  initial begin
    int d0;
    int n;

    tab[0] = '{8'h10, 0, 1, 16};
    tab[1] = '{8'h10, 1, 1, 16};
    tab[2] = '{8'hA0, 0, 2, 32};
    tab[3] = '{8'h60, 2, 2, 32};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 4; t++) begin
      mode = tab[t].rmode;
      d0   = xfers;
      for (int b = 0; b < tab[t].nblk; b++) offer(tab[t].base + 8'(16 * b));
      if (tab[t].nblk == 2) chk("in_ready_low_with_pend", 32'(in_ready), 32'd0);
      drain();
      chk("xfer_count", 32'(xfers - d0), 32'(tab[t].exp_count));
    end

    // Reset mid-block with a block pending.
    mode = 0;
    offer(8'hA0);
    offer(8'hB0);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (q.size() != 26 && n < 200);
    chk("reach_a5", 32'(q.size()), 32'd26);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    #1;
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o", 32'(o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    d0 = xfers;
    offer(8'hD0);
    drain();
    chk("d_count", 32'(xfers - d0), 32'd16);

    // Accept C on the exact cycle AF transfers with pend empty.
    offer(8'hA0);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!(o_valid && o_ready && o_last && q.size() == 0) && n < 200);
    chk("reach_af", 32'(o), 32'h0af);
    in_valid = 1'b1;
    i        = mk(8'hC0);
    @(posedge clk);
    push_blk(8'hC0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("c_no_pend", 32'(in_ready), 32'd1);
    chk("c_first", 32'(o), 32'h0c0);
    drain();

    // Three blocks offered with in_valid held high.
    d0 = xfers;
    n  = done;
    offer(8'h30);
    offer(8'h40);
    chk("two_accepted", 32'(in_ready), 32'd0);
    offer(8'h50);
    chk("third_after_first", 32'(done - n), 32'd1);
    drain();
    chk("three_count", 32'(xfers - d0), 32'd48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
